// File: rtl/fp_mult_link_host_pkg.sv
// Shared types and constants for the host side of the
// byte-serial FP multiplier link.
package fp_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_t;

  localparam int TX_BYTES = 16;
  localparam int RX_BYTES = 8;

  localparam logic [63:0] FP64_QNAN =
    64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_mult_link_host_if.sv
// Byte-serial link between host initiator
// and the FP multiplier.
interface fp_mult_link_host_if;

  logic       LINK_RESET;
  logic       LINK_ENABLE;
  logic [7:0] LINK_DATA_OUT;
  logic [7:0] LINK_DATA_IN;
  logic       LINK_READY;

  modport master (
    output LINK_RESET,
    output LINK_ENABLE,
    output LINK_DATA_OUT,
    input  LINK_DATA_IN,
    input  LINK_READY
  );

  modport slave (
    input  LINK_RESET,
    input  LINK_ENABLE,
    input  LINK_DATA_OUT,
    output LINK_DATA_IN,
    output LINK_READY
  );

endinterface

// File: rtl/fp_mult_link_host.sv
// Host initiator: serializes X/Y to the multiplier,
// collects the 8-byte product, pulses DONE.
module fp_mult_link_host
  import fp_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [63:0] X,
  input  logic [63:0] Y,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [63:0] RESULT,
  fp_mult_link_host_if.master link
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] TX_LAST = 4'(TX_BYTES - 1);
  localparam logic [2:0] RX_LAST = 3'(RX_BYTES - 1);

  state_t r_state;
  state_t w_next;

  logic [127:0]  r_sr;
  logic [3:0]    r_tx_cnt;
  logic [2:0]    r_rx_cnt;
  logic [WW-1:0] r_wait_cnt;

  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_link_reset;
  logic        r_link_en;
  logic [7:0]  r_dout;
  logic [63:0] r_result;

  logic w_accept;
  logic w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && START;
  assign w_timeout = (r_state == ST_WAIT)
                  && !link.LINK_READY
                  && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (START) w_next = ST_SEND;
      ST_SEND: if (r_tx_cnt == TX_LAST) w_next = ST_WAIT;
      ST_WAIT: begin
        if (link.LINK_READY) w_next = ST_RECV;
        else if (w_timeout)  w_next = ST_DONE;
      end
      ST_RECV: if (r_rx_cnt == RX_LAST) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_link_reset <= 1'b1;
      r_link_en    <= 1'b0;
      r_dout       <= 8'h00;
      r_result     <= 64'h0;
      r_sr         <= '0;
      r_tx_cnt     <= '0;
      r_rx_cnt     <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_busy       <= (w_next != ST_IDLE);
      r_done       <= (w_next == ST_DONE);
      r_error      <= w_timeout;
      r_link_reset <= (w_next == ST_IDLE)
                   || (w_next == ST_DONE);
      r_link_en    <= (w_next == ST_SEND);

      if (w_accept) begin
        r_sr       <= {8'h00, Y, X[63:8]};
        r_dout     <= X[7:0];
        r_tx_cnt   <= '0;
        r_rx_cnt   <= '0;
        r_wait_cnt <= '0;
      end else if (r_state == ST_SEND) begin
        r_sr     <= {8'h00, r_sr[127:8]};
        r_dout   <= (w_next == ST_SEND) ? r_sr[7:0] : 8'h00;
        r_tx_cnt <= r_tx_cnt + 4'd1;
      end

      if (r_state == ST_WAIT) begin
        if (link.LINK_READY) begin
          r_result[7:0] <= link.LINK_DATA_IN;
          r_rx_cnt      <= 3'd1;
        end else if (w_timeout) begin
          r_result <= FP64_QNAN;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end

      if (r_state == ST_RECV) begin
        r_result[{r_rx_cnt, 3'b000} +: 8] <= link.LINK_DATA_IN;
        r_rx_cnt <= r_rx_cnt + 3'd1;
      end
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign ERROR  = r_error;
  assign RESULT = r_result;

  assign link.LINK_RESET    = r_link_reset;
  assign link.LINK_ENABLE   = r_link_en;
  assign link.LINK_DATA_OUT = r_dout;

endmodule

// File: tb/tb_fp_mult_link_host.sv
// Bench for fp_mult_link_host with a behavioural
// multiplier on the far side of the link.
module tb_fp_mult_link_host;
  import fp_link_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET, START, START2;
  logic [63:0] X, Y, X2, Y2;
  logic        BUSY, DONE, ERROR;
  logic        BUSY2, DONE2, ERROR2;
  logic [63:0] RESULT, RESULT2;

  fp_mult_link_host_if lk ();
  fp_mult_link_host_if lk2 ();

  fp_mult_link_host dut (
    .CLK(clk), .RESET(RESET), .START(START),
    .X(X), .Y(Y), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .RESULT(RESULT), .link(lk)
  );

  fp_mult_link_host #(.TIMEOUT_CYCLES(8)) dut2 (
    .CLK(clk), .RESET(RESET), .START(START2),
    .X(X2), .Y(Y2), .BUSY(BUSY2), .DONE(DONE2),
    .ERROR(ERROR2), .RESULT(RESULT2), .link(lk2)
  );

  assign lk2.LINK_READY   = 1'b0;
  assign lk2.LINK_DATA_IN = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: 16 bytes in, gap, 8 bytes out
  int  rsp_gap   = 1;
  bit  rsp_fixed = 1'b0;
  logic [127:0] m_buf;
  logic [63:0]  m_res;
  int m_cnt, m_dly, m_idx, m_ph;

  function automatic logic [63:0] rsp_val(input logic [127:0] b);
    if (rsp_fixed) return 64'h8877_6655_4433_2211;
    return $realtobits($bitstoreal(b[63:0]) *
                       $bitstoreal(b[127:64]));
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] v,
                                         input int i);
    return v[i*8 +: 8];
  endfunction

  always @(posedge clk) begin
    if (lk.LINK_RESET) begin
      m_cnt <= 0; m_ph <= 0; m_dly <= 0; m_idx <= 0;
      lk.LINK_READY   <= 1'b0;
      lk.LINK_DATA_IN <= 8'h00;
    end else begin
      case (m_ph)
        0: if (lk.LINK_ENABLE) begin
          m_buf[m_cnt*8 +: 8] <= lk.LINK_DATA_OUT;
          m_cnt <= m_cnt + 1;
          if (m_cnt == 15) begin m_ph <= 1; m_dly <= 0; end
        end
        1: begin
          if (m_dly == rsp_gap - 1) begin
            m_res           <= rsp_val(m_buf);
            lk.LINK_READY   <= 1'b1;
            lk.LINK_DATA_IN <= byte_of(rsp_val(m_buf), 0);
            m_idx <= 1;
            m_ph  <= 2;
          end else begin
            m_dly <= m_dly + 1;
          end
        end
        2: begin
          lk.LINK_READY   <= 1'b0;
          lk.LINK_DATA_IN <= byte_of(m_res, m_idx);
          m_idx <= m_idx + 1;
          if (m_idx == 7) m_ph <= 3;
        end
        default: lk.LINK_DATA_IN <= 8'h00;
      endcase
    end
  end

  // Results of one transaction on dut
  logic [7:0]  txq[$];
  int          en_first, en_last;
  int          t_lat, t_dcnt;
  logic [63:0] t_res;
  logic        t_err, t_busy_after;

  task automatic run_txn(input logic [63:0] x,
                         input logic [63:0] y,
                         input bit glitch);
    txq.delete();
    en_first = -1; en_last = -1;
    t_lat = -1; t_dcnt = 0; t_res = 'x; t_err = 1'bx;
    t_busy_after = 1'bx;
    @(negedge clk);
    START = 1'b1; X = x; Y = y;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        START = 1'b0;
        if (glitch) begin X = ~x; Y = ~y; end
      end
      if (glitch && k == 6) begin
        START = 1'b1; X = 64'h3FF0_0000_0000_0000; Y = X;
      end
      if (glitch && k == 7) START = 1'b0;
      if (lk.LINK_ENABLE) begin
        txq.push_back(lk.LINK_DATA_OUT);
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if (DONE) begin
        t_dcnt++;
        if (t_lat < 0) begin
          t_lat = k; t_res = RESULT; t_err = ERROR;
          if (glitch) begin
            START = 1'b1; X = 64'h4010_0000_0000_0000;
          end
        end
      end
      if (t_lat > 0 && k == t_lat + 1) begin
        START = 1'b0;
        t_busy_after = BUSY;
      end
      if (t_lat > 0 && k == t_lat + 4) break;
    end
  endtask

  task automatic chk_bytes(input string tag,
                           input logic [63:0] x,
                           input logic [63:0] y);
    logic [127:0] pk;
    pk = '0;
    for (int i = 0; i < txq.size() && i < 16; i++)
      pk[i*8 +: 8] = txq[i];
    chk({tag, "_nbytes"}, 64'(txq.size()), 64'd16);
    chk({tag, "_span"}, 64'(en_last - en_first), 64'd15);
    chk({tag, "_xbytes"}, pk[63:0], x);
    chk({tag, "_ybytes"}, pk[127:64], y);
  endtask

  initial begin
    logic [63:0] rx, ry, exp;
    int          lat2, dc;
    logic [63:0] r2;
    logic        e2;

    RESET = 1'b1; START = 1'b0; X = '0; Y = '0;
    START2 = 1'b0; X2 = '0; Y2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(BUSY), 64'd0);
    chk("rst_done",  64'(DONE), 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    chk("rst_lrst",  64'(lk.LINK_RESET), 64'd1);
    chk("rst_len",   64'(lk.LINK_ENABLE), 64'd0);
    chk("rst_dout",  64'(lk.LINK_DATA_OUT), 64'd0);
    chk("rst_result", RESULT, 64'd0);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // 3.0 * 2.0
    rsp_gap = 2;
    run_txn(64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    chk_bytes("t1", 64'h4008_0000_0000_0000,
              64'h4000_0000_0000_0000);
    chk("t1_result", t_res, 64'h4018_0000_0000_0000);
    chk("t1_error", 64'(t_err), 64'd0);
    chk("t1_dcnt", 64'(t_dcnt), 64'd1);
    chk("t1_lat", 64'(t_lat), 64'(1 + 16 + 2 + 8));
    chk("t1_busy_after", 64'(t_busy_after), 64'd0);

    // fixed response bytes, READY five cycles after ENABLE falls
    rsp_fixed = 1'b1; rsp_gap = 5;
    run_txn(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0);
    chk("t2_lat", 64'(t_lat), 64'(1 + 16 + 5 + 8));
    chk("t2_result", t_res, 64'h8877_6655_4433_2211);
    rsp_fixed = 1'b0;

    // READY never arrives on dut2
    @(negedge clk);
    START2 = 1'b1; X2 = 64'h4008_0000_0000_0000; Y2 = X2;
    lat2 = -1; r2 = '0; e2 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) START2 = 1'b0;
      if (DONE2) begin
        lat2 = k; r2 = RESULT2; e2 = ERROR2;
        break;
      end
    end
    chk("t3_lat", 64'(lat2), 64'(1 + 16 + 8));
    chk("t3_error", 64'(e2), 64'd1);
    chk("t3_result", r2, FP64_QNAN);
    @(negedge clk);
    chk("t3_busy_after", 64'(BUSY2), 64'd0);
    chk("t3_done_after", 64'(DONE2), 64'd0);

    // reset while byte 6 is on the link
    rx = 64'h1122_3344_5566_7788;
    @(negedge clk);
    START = 1'b1; X = rx; Y = ~rx;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) START = 1'b0;
    end
    chk("t4_byte6", 64'(lk.LINK_DATA_OUT), 64'(rx[55:48]));
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    chk("t4_lrst", 64'(lk.LINK_RESET), 64'd1);
    chk("t4_len", 64'(lk.LINK_ENABLE), 64'd0);
    chk("t4_busy", 64'(BUSY), 64'd0);
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (DONE) dc++;
    end
    chk("t4_no_done", 64'(dc), 64'd0);
    rsp_gap = 1;
    run_txn(64'hC004_0000_0000_0000, 64'h3FE0_0000_0000_0000, 0);
    chk("t4_fresh_result", t_res, 64'hBFF4_0000_0000_0000);
    chk("t4_fresh_lat", 64'(t_lat), 64'(1 + 16 + 1 + 8));

    // STARTs during SEND and during the DONE cycle
    rsp_gap = 3;
    rx = 64'h4014_0000_0000_0000;
    ry = 64'hC01C_0000_0000_0000;
    run_txn(rx, ry, 1);
    chk_bytes("t5", rx, ry);
    chk("t5_result", t_res, 64'hC041_8000_0000_0000);
    chk("t5_dcnt", 64'(t_dcnt), 64'd1);
    chk("t5_busy_after", 64'(t_busy_after), 64'd0);

    // random operands through the behavioural multiplier
    for (int i = 0; i < 300; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rsp_gap = int'($urandom_range(1, 4));
      exp = $realtobits($bitstoreal(rx) * $bitstoreal(ry));
      run_txn(rx, ry, 0);
      chk("rnd_result", t_res, exp);
      chk("rnd_error", 64'(t_err), 64'd0);
      chk("rnd_lat", 64'(t_lat), 64'(25 + rsp_gap));
      chk("rnd_dcnt", 64'(t_dcnt), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
